// File: rtl/aes_block_serializer_pkg.sv
// Shared types and sizes for the AES output block serializer.
// The engine and the serializer agree on block/word geometry through these constants.
package aes_block_serializer_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_NWORDS  = AES_BLOCK_W / AES_WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } aes_ser_state_t;

  // Status bundle exported towards the controller's flag register.
  typedef struct packed {
    logic                          busy;
    logic [$clog2(AES_NWORDS)-1:0] word_cnt;
    logic                          block_done;
  } flags_serializer_t;

endpackage

// File: rtl/aes_block_serializer.sv
// Splits one AES result block into WORD_W-bit words on a valid/ready stream source.
// Output data comes only from the hold register through a word mux.
module aes_block_serializer
  import aes_block_serializer_pkg::*;
#(
  parameter int unsigned BLOCK_W   = AES_BLOCK_W,
  parameter int unsigned WORD_W    = AES_WORD_W,
  parameter bit          MSW_FIRST = 1'b0,
  localparam int unsigned NWORDS   = BLOCK_W / WORD_W,
  localparam int unsigned CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [BLOCK_W-1:0]  blk_data_i,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  output logic [WORD_W-1:0]   d_data_o,
  output logic [WORD_W/8-1:0] d_strb_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    word_cnt_o,
  output logic                block_done_o
);

  aes_ser_state_t     state_q, state_d;
  logic [BLOCK_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_word;

  function automatic logic [WORD_W-1:0] pick_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [CNT_W-1:0]   idx);
    int unsigned sel;
    sel = MSW_FIRST ? (NWORDS - 1 - 32'(idx)) : 32'(idx);
    return blk[sel*WORD_W +: WORD_W];
  endfunction

  assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear wins over everything; the last-word handshake can accept the next block directly.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    blk_ready_o  = 1'b0;
    block_done_o = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      hold_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          blk_ready_o = 1'b1;
          if (blk_valid_i) begin
            hold_d  = blk_data_i;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (d_ready_i) begin
            if (last_word) begin
              block_done_o = 1'b1;
              blk_ready_o  = 1'b1;
              cnt_d        = '0;
              if (blk_valid_i) begin
                hold_d = blk_data_i;
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d_valid_o  = (state_q == SEND);
  assign busy_o     = (state_q == SEND);
  assign word_cnt_o = cnt_q;
  assign d_data_o   = (state_q == SEND) ? pick_word(hold_q, cnt_q) : '0;
  assign d_strb_o   = '1;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Scoreboard bench: accepted blocks become expected word sequences, a monitor checks the stream.
module tb_aes_block_serializer;

  localparam int NW = 4;

  typedef struct {
    logic [127:0] blk;
    int           idx;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic [127:0] blk_data_i = '0;
  logic         d_ready_i = 1'b1;
  logic         blk_ready_o, d_valid_o, busy_o, block_done_o;
  logic [31:0]  d_data_o;
  logic [3:0]   d_strb_o;
  logic [1:0]   word_cnt_o;
  logic         blk_ready_m, d_valid_m, busy_m, block_done_m;
  logic [31:0]  d_data_m;
  logic [3:0]   d_strb_m;
  logic [1:0]   word_cnt_m;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  always #5 clk_i = ~clk_i;

  aes_block_serializer #(.MSW_FIRST(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o), .d_strb_o(d_strb_o),
    .busy_o(busy_o), .word_cnt_o(word_cnt_o), .block_done_o(block_done_o)
  );

  aes_block_serializer #(.MSW_FIRST(1'b1)) dut_msw (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_m), .blk_data_i(blk_data_i),
    .d_valid_o(d_valid_m), .d_ready_i(d_ready_i), .d_data_o(d_data_m), .d_strb_o(d_strb_m),
    .busy_o(busy_m), .word_cnt_o(word_cnt_m), .block_done_o(block_done_m)
  );

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    logic [127:0] s;
    s = b >> (32 * i);
    return s[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every word handshake and enforces stream stability.
  initial begin
    logic        prev_valid, prev_ready, prev_clear;
    logic [31:0] prev_data;
    exp_t        e;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_clear = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready && !prev_clear) begin
          checkOutput("hold_valid", 128'(d_valid_o), 128'(1));
          checkOutput("hold_data", 128'(d_data_o), 128'(prev_data));
        end
        checkOutput("msw_valid_match", 128'(d_valid_m), 128'(d_valid_o));
        if (clear_i) begin
          checkOutput("clear_no_done", 128'(block_done_o), 128'(0));
          checkOutput("clear_no_ready", 128'(blk_ready_o), 128'(0));
          exp_q.delete();
        end else begin
          if (d_valid_o && d_ready_i) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_word: got %0h, expected no word at %0t", d_data_o, $time);
            end else begin
              e = exp_q.pop_front();
              checkOutput("word_data", 128'(d_data_o), 128'(word_of(e.blk, e.idx)));
              checkOutput("word_data_msw", 128'(d_data_m), 128'(word_of(e.blk, NW - 1 - e.idx)));
              checkOutput("word_cnt", 128'(word_cnt_o), 128'(e.idx));
              checkOutput("block_done", 128'(block_done_o), 128'(e.idx == NW - 1));
              checkOutput("strobe", 128'(d_strb_o), 128'(4'hF));
              if (block_done_o) done_count++;
            end
          end else begin
            checkOutput("no_spurious_done", 128'(block_done_o), 128'(0));
          end
          if (blk_valid_i && blk_ready_o) begin
            for (int i = 0; i < NW; i++) exp_q.push_back('{blk: blk_data_i, idx: i});
          end
        end
        prev_valid = d_valid_o;
        prev_ready = d_ready_i;
        prev_clear = clear_i;
        prev_data  = d_data_o;
      end
    end
  end

  // Offers one block and waits (bounded) until it is taken; returns early in the next cycle.
  task automatic applyStimulus(input logic [127:0] blk, input int budget);
    int n;
    @(posedge clk_i); #1;
    blk_valid_i = 1'b1;
    blk_data_i  = blk;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (blk_ready_o) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("[TB] FAIL block_accept_timeout: got no ready, expected ready within %0d cycles", budget);
        break;
      end
    end
    @(posedge clk_i); #1;
    blk_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input int cycles);
    repeat (cycles) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] blk_a, blk_b;
    int           base, n;
    logic         acc;

    // Reset values
    #1;
    checkOutput("rst_valid", 128'(d_valid_o), 128'(0));
    checkOutput("rst_busy", 128'(busy_o), 128'(0));
    checkOutput("rst_cnt", 128'(word_cnt_o), 128'(0));
    checkOutput("rst_done", 128'(block_done_o), 128'(0));
    checkOutput("rst_data", 128'(d_data_o), 128'(0));
    checkOutput("rst_strb", 128'(d_strb_o), 128'(4'hF));
    #20;
    rst_ni = 1'b1;
    waitIdle(2);

    // Single block with the stream always ready
    $display("[TB] single block");
    blk_a = 128'h33333333_22222222_11111111_00000000;
    base  = done_count;
    applyStimulus(blk_a, 5);
    for (int k = 1; k <= NW; k++) begin
      @(negedge clk_i);
      checkOutput("lat_valid", 128'(d_valid_o), 128'(1));
      checkOutput("lat_done", 128'(block_done_o), 128'(k == NW));
      checkOutput("lat_data", 128'(d_data_o), 128'(word_of(blk_a, k - 1)));
      checkOutput("lat_data_msw", 128'(d_data_m), 128'(word_of(blk_a, NW - k)));
    end
    @(negedge clk_i);
    checkOutput("after_valid", 128'(d_valid_o), 128'(0));
    checkOutput("after_ready", 128'(blk_ready_o), 128'(1));
    checkOutput("after_busy", 128'(busy_o), 128'(0));
    checkOutput("single_done_cnt", 128'(done_count - base), 128'(1));
    waitIdle(2);

    // Backpressure holds word 1
    $display("[TB] backpressure");
    base = done_count;
    applyStimulus(blk_a, 5);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    d_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("bp_valid", 128'(d_valid_o), 128'(1));
      checkOutput("bp_data", 128'(d_data_o), 128'(32'h11111111));
      checkOutput("bp_cnt", 128'(word_cnt_o), 128'(1));
      @(posedge clk_i); #1;
    end
    d_ready_i = 1'b1;
    waitIdle(6);
    checkOutput("bp_done_cnt", 128'(done_count - base), 128'(1));
    checkOutput("bp_drained", 128'(exp_q.size()), 128'(0));

    // Back-to-back blocks with no bubble
    $display("[TB] back-to-back");
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    blk_valid_i = 1'b1;
    blk_data_i  = blk_a;
    @(negedge clk_i);
    checkOutput("b2b_ready_a", 128'(blk_ready_o), 128'(1));
    @(posedge clk_i); #1;
    blk_data_i = blk_b;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      checkOutput("b2b_valid", 128'(d_valid_o), 128'(1));
      checkOutput("b2b_ready", 128'(blk_ready_o), 128'(c == 4 || c == 8));
      if (c == 4) begin
        @(posedge clk_i); #1;
        blk_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    checkOutput("b2b_end_valid", 128'(d_valid_o), 128'(0));
    waitIdle(2);

    // Clear after the first word, then a fresh block
    $display("[TB] clear");
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    base  = done_count;
    applyStimulus(blk_a, 5);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    clear_i     = 1'b1;
    blk_valid_i = 1'b1;
    blk_data_i  = blk_b;
    @(negedge clk_i);
    checkOutput("clr_ready_forced", 128'(blk_ready_o), 128'(0));
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    checkOutput("clr_valid", 128'(d_valid_o), 128'(0));
    checkOutput("clr_busy", 128'(busy_o), 128'(0));
    checkOutput("clr_cnt", 128'(word_cnt_o), 128'(0));
    checkOutput("clr_done", 128'(block_done_o), 128'(0));
    checkOutput("clr_ready_idle", 128'(blk_ready_o), 128'(1));
    @(posedge clk_i); #1;
    blk_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("clr_b_word0", 128'(d_data_o), 128'(word_of(blk_b, 0)));
    checkOutput("clr_b_cnt", 128'(word_cnt_o), 128'(0));
    waitIdle(5);
    checkOutput("clr_done_cnt", 128'(done_count - base), 128'(1));

    // Asynchronous reset in the middle of a block
    $display("[TB] reset mid-block");
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk_a, 5);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_valid", 128'(d_valid_o), 128'(0));
    checkOutput("arst_data", 128'(d_data_o), 128'(0));
    checkOutput("arst_busy", 128'(busy_o), 128'(0));
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("arst_ready", 128'(blk_ready_o), 128'(1));
    checkOutput("arst_idle_valid", 128'(d_valid_o), 128'(0));
    waitIdle(2);

    // Randomized traffic with random backpressure and occasional clears
    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      acc = blk_valid_i && blk_ready_o;
      @(posedge clk_i); #1;
      if (!blk_valid_i || acc || clear_i) begin
        blk_valid_i = ($urandom_range(0, 2) != 0);
        blk_data_i  = {$urandom, $urandom, $urandom, $urandom};
      end
      d_ready_i = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 99) == 0);
    end
    blk_valid_i = 1'b0;
    clear_i     = 1'b0;
    d_ready_i   = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("rand_drained", 128'(exp_q.size()), 128'(0));
    waitIdle(2);
    checkOutput("rand_idle_busy", 128'(busy_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
